huffman_packer: RTL
===================

HUFFMAN_PACKER -- requirements
Module: huffman_packer

Interface
REQ-001 SHALL have ports: clk  in  1  clock, all state on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: code_valid  in  1  one-cycle strobe, code table valid.
REQ-004 SHALL have ports: HC1..HC6  in  8 each  code per symbol 1..6, right-aligned.
REQ-005 SHALL have ports: M1..M6  in  8 each  mask per symbol, contiguous ones from LSB; code length = popcount.
REQ-006 SHALL have ports: sym_valid  in  1  symbol present.
REQ-007 SHALL have ports: sym_data  in  8  symbol value, legal 1..6.
REQ-008 SHALL have ports: sym_last  in  1  final symbol of frame, qualified by sym_valid.
REQ-009 SHALL have ports: sym_ready  out  1  symbol accepted when sym_valid && sym_ready.
REQ-010 SHALL have ports: out_valid  out  1  packed byte present.
REQ-011 SHALL have ports: out_data  out  8  packed byte, first code bit in bit 7.
REQ-012 SHALL have ports: out_last  out  1  final byte of frame, qualified by out_valid.
REQ-013 SHALL have ports: out_ready  in  1  byte consumed when out_valid && out_ready.
REQ-014 SHALL have ports: err_sym  out  1  one-cycle pulse, illegal symbol consumed.
REQ-015 SHALL have ports: busy  out  1  high whenever state != IDLE.

Function
REQ-016 SHALL implement states IDLE, RUN, FLUSH.
REQ-017 IDLE: on code_valid, SHALL latch HC1..6 and M1..6, compute len1..6 (0..8), go to RUN next cycle.
REQ-018 code_valid outside IDLE SHALL be ignored; the table stays unchanged.
REQ-019 SHALL hold a 16-bit accumulator acc, MSB-aligned, plus a 5-bit bit count cnt (0..16).
- Bits below cnt SHALL always be zero.
REQ-020 RUN: sym_ready SHALL be high iff cnt <= 8; in IDLE and FLUSH, sym_ready SHALL be 0.
REQ-021 Accepting legal symbol n SHALL append its lenn code bits MSB-first (bit lenn-1 first) at position cnt.
REQ-022 Accepting a symbol outside 1..6 SHALL append no bits and pulse err_sym the following cycle.
REQ-023 A symbol with M=0 SHALL append no bits and SHALL NOT flag an error.
REQ-024 RUN: out_valid SHALL be high iff cnt >= 8.
- out_data = acc[15:8]; out_last = 0.
- A pop shifts acc left by 8 and subtracts 8 from cnt.
REQ-025 A push and a pop in the same cycle SHALL both take effect: cnt_next = cnt + len - 8, acc aligned accordingly.
REQ-026 Accepting a symbol with sym_last SHALL move to FLUSH next cycle, after its bits are appended.
REQ-027 FLUSH: out_valid SHALL be 1; out_data = acc[15:8], zero-padded in the LSBs.
- out_last SHALL be 1 iff cnt <= 8.
- Each pop subtracts min(cnt, 8).
- The pop with out_last SHALL return the block to IDLE.
REQ-028 FLUSH entered with cnt = 0 SHALL emit exactly one byte 0x00 with out_last = 1.
REQ-029 While out_valid && !out_ready, out_data and out_last SHALL stay stable.
REQ-030 The table SHALL be cleared on return to IDLE; every frame requires a fresh code_valid.
REQ-031 Throughput SHALL be one symbol per cycle and one byte per cycle when unstalled.
- Latency from symbol accept to the byte containing its first bit: >= 1 cycle.

Reset
REQ-032 Asserting reset SHALL force the following immediately, including mid-frame:
- state IDLE, acc = 0, cnt = 0, table = 0.
- sym_ready, out_valid, out_last, err_sym, busy all 0; out_data = 0x00.
REQ-033 After reset deassertion, the first byte SHALL only follow a new code_valid and new symbols.

Verification
Table used in all scenarios: HC1=0x00 M1=0x01, HC2=0x02 M2=0x03, HC3=0x06 M3=0x07, HC4=0x0E M4=0x0F, HC5=0x1E M5=0x1F, HC6=0x1F M6=0x1F.
REQ-034 Symbols 1,2,3 (last on 3), out_ready=1 -> one byte 0x58, out_last=1, then IDLE.
REQ-035 Eight symbol 1s, last on 8th -> one byte 0x00, out_last=1 (cnt exactly 8, no extra pad byte).
REQ-036 Symbols 6,6,6,6, last -> bytes 0xFF, 0xFF, 0xF0; out_last only on 0xF0.
REQ-037 out_ready=0 while streaming symbol 6s -> sym_ready drops once cnt > 8; out_data held stable; bytes resume correctly on release.
REQ-038 sym_data=0x07 mid-frame -> err_sym single pulse, bitstream unchanged; if it carries sym_last with cnt = 0 -> byte 0x00, out_last=1.
REQ-039 reset asserted in RUN with cnt=5 -> all outputs 0 at once; post-reset symbols are ignored until code_valid.

Source files
------------

// File: rtl/huffman_packer.sv
// Huffman code packer: maps symbols 1..6 to variable-length codes from a per-frame table
// and packs them MSB-first into bytes, zero-padding the final byte of each frame.
module huffman_packer (
    input  logic       clk,
    input  logic       reset,
    input  logic       code_valid,
    input  logic [7:0] HC1,
    input  logic [7:0] HC2,
    input  logic [7:0] HC3,
    input  logic [7:0] HC4,
    input  logic [7:0] HC5,
    input  logic [7:0] HC6,
    input  logic [7:0] M1,
    input  logic [7:0] M2,
    input  logic [7:0] M3,
    input  logic [7:0] M4,
    input  logic [7:0] M5,
    input  logic [7:0] M6,
    input  logic       sym_valid,
    input  logic [7:0] sym_data,
    input  logic       sym_last,
    output logic       sym_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic       err_sym,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t      state, state_next;
    logic [7:0]  hc_in [1:6];
    logic [7:0]  m_in  [1:6];
    logic [7:0]  code_q [1:6];
    logic [3:0]  len_q  [1:6];
    logic [15:0] acc, acc_next, base_acc;
    logic [4:0]  cnt, cnt_next, base_cnt;
    logic        err_next;
    logic        sel_legal, push, pop;
    logic [7:0]  sel_code, code_al;
    logic [3:0]  sel_len;

    function automatic logic [3:0] popcount8(input logic [7:0] m);
        logic [3:0] c;
        c = '0;
        for (int unsigned i = 0; i < 8; i++) c = c + {3'b000, m[i]};
        return c;
    endfunction

    assign hc_in[1] = HC1;  assign m_in[1] = M1;
    assign hc_in[2] = HC2;  assign m_in[2] = M2;
    assign hc_in[3] = HC3;  assign m_in[3] = M3;
    assign hc_in[4] = HC4;  assign m_in[4] = M4;
    assign hc_in[5] = HC5;  assign m_in[5] = M5;
    assign hc_in[6] = HC6;  assign m_in[6] = M6;

    // Codes are stored masked so bits beyond the code length never leak into acc.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 1; k <= 6; k++) begin
                code_q[k] <= '0;
                len_q[k]  <= '0;
            end
        end else if (state == IDLE && code_valid) begin
            for (int unsigned k = 1; k <= 6; k++) begin
                code_q[k] <= hc_in[k] & m_in[k];
                len_q[k]  <= popcount8(m_in[k]);
            end
        end else if (state == FLUSH && state_next == IDLE) begin
            for (int unsigned k = 1; k <= 6; k++) begin
                code_q[k] <= '0;
                len_q[k]  <= '0;
            end
        end
    end

    always_comb begin
        sel_legal = (sym_data >= 8'd1) && (sym_data <= 8'd6);
        sel_code  = '0;
        sel_len   = '0;
        for (int unsigned k = 1; k <= 6; k++) begin
            if (sym_data == 8'(k)) begin
                sel_code = code_q[k];
                sel_len  = len_q[k];
            end
        end
        code_al = sel_code << (4'd8 - sel_len);
    end

    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        err_next   = 1'b0;
        sym_ready  = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        base_acc   = acc;
        base_cnt   = cnt;
        case (state)
            IDLE: begin
                if (code_valid) state_next = RUN;
            end
            RUN: begin
                sym_ready = (cnt <= 5'd8);
                out_valid = (cnt >= 5'd8);
                push      = sym_valid && sym_ready;
                pop       = out_valid && out_ready;
                // Pop first, then append at the post-pop position; both only coincide at cnt == 8.
                if (pop) begin
                    base_acc = acc << 8;
                    base_cnt = cnt - 5'd8;
                end
                acc_next = base_acc;
                cnt_next = base_cnt;
                if (push) begin
                    if (sel_legal) begin
                        acc_next = base_acc | ({code_al, 8'h00} >> base_cnt);
                        cnt_next = base_cnt + {1'b0, sel_len};
                    end else begin
                        err_next = 1'b1;
                    end
                    if (sym_last) state_next = FLUSH;
                end
            end
            FLUSH: begin
                out_valid = 1'b1;
                out_last  = (cnt <= 5'd8);
                if (out_ready) begin
                    if (out_last) begin
                        state_next = IDLE;
                        acc_next   = '0;
                        cnt_next   = '0;
                    end else begin
                        acc_next = acc << 8;
                        cnt_next = cnt - 5'd8;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            err_sym <= 1'b0;
        end else begin
            state   <= state_next;
            acc     <= acc_next;
            cnt     <= cnt_next;
            err_sym <= err_next;
        end
    end

    assign out_data = acc[15:8];
    assign busy     = (state != IDLE);
endmodule
